// File: rtl/wb_pkg.sv
// Shared Wishbone address-window constants and the BRAM responder state encoding.
// The response decoder uses the same base constants.
package wb_pkg;

  localparam logic [11:0] USER_BRAM_BASE_HI = 12'h380;
  localparam logic [11:0] USER_UART_BASE_HI = 12'h300;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } resp_state_t;

  function automatic logic adr_in_window(input logic [31:0] adr, input logic [11:0] base_hi);
    return adr[31:20] == base_hi;
  endfunction

endpackage

// File: rtl/bram_sp_bw.sv
// Single-port BRAM with four byte-write lanes and a registered, read-first output.
module bram_sp_bw #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       q
);

  logic [31:0] r_mem [2**ADDR_W];

  // q holds its value between accesses, so the responder can present it after the access edge.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= r_mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) r_mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_bram_responder.sv
// Wishbone classic slave for the user-project BRAM window with a fixed number of wait states.
// The request is latched in IDLE; the BRAM access and a one-cycle ack follow after DELAY waits.
module wb_bram_responder
  import wb_pkg::*;
#(
  parameter logic [11:0] BASE_HI = USER_BRAM_BASE_HI,
  parameter int          ADDR_W  = 10,
  parameter int          DELAY   = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  resp_state_t       r_state;
  resp_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ack;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [31:0]       r_din;
  logic [ADDR_W-1:0] r_idx;

  logic              w_hit;
  logic              w_accept;
  logic              w_mem_en;
  logic [3:0]        w_mem_we;
  logic [31:0]       w_q;
  logic              w_unused_adr;

  assign w_hit        = wbs_cyc_i & wbs_stb_i & adr_in_window(wbs_adr_i, BASE_HI);
  assign w_unused_adr = &{1'b0, wbs_adr_i[19:ADDR_W+2], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (r_state == ST_ACK);
      if (w_accept) begin
        r_cnt <= CNT_W'(DELAY);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // The BRAM is only enabled while in ACK and out of reset, so aborted writes never commit.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mem_en = 1'b0;
    w_mem_we = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_accept = 1'b1;
          w_next   = (DELAY > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          w_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next = ST_ACK;
        end
      end
      ST_ACK: begin
        w_next   = ST_IDLE;
        w_mem_en = wb_rst_i;
        w_mem_we = r_we ? r_sel : 4'b0000;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_accept) begin
      r_we  <= wbs_we_i;
      r_sel <= wbs_sel_i;
      r_din <= wbs_dat_i;
      r_idx <= wbs_adr_i[ADDR_W+1:2];
    end
  end

  bram_sp_bw #(
    .ADDR_W(ADDR_W)
  ) u_bram (
    .clk (wb_clk_i),
    .en  (w_mem_en),
    .we  (w_mem_we),
    .addr(r_idx),
    .din (r_din),
    .q   (w_q)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = (r_ack && !r_we) ? w_q : 32'h0;

endmodule

// File: tb/tb_wb_bram_responder.sv
// Bench for wb_bram_responder: a DELAY=10 and a DELAY=0 instance side by side,
// driven by a vector table, hand-written corner sequences and random traffic against a word-array model.
module tb_wb_bram_responder;
  import wb_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int DELAY_A = 10;
  localparam int DELAY_B = 0;

  logic        clk;
  logic        rstN;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] datI [2];
  logic [31:0] datO [2];
  logic        ack  [2];

  logic [31:0] memModel [2][DEPTH];
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          expAck;
    logic [31:0] expRd;
  } vec_t;

  wb_bram_responder #(.BASE_HI(USER_BRAM_BASE_HI), .ADDR_W(ADDR_W), .DELAY(DELAY_A)) dutA (
    .wb_clk_i(clk), .wb_rst_i(rstN), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(datI[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(datO[0])
  );

  wb_bram_responder #(.BASE_HI(USER_BRAM_BASE_HI), .ADDR_W(ADDR_W), .DELAY(DELAY_B)) dutB (
    .wb_clk_i(clk), .wb_rst_i(rstN), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(datI[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(datO[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int delayOf(input int d);
    return (d == 0) ? DELAY_A : DELAY_B;
  endfunction

  function automatic bit inWindow(input logic [31:0] a);
    return (a >> 20) == 32'(USER_BRAM_BASE_HI);
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic releaseBus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    sel[d] = 4'h0; adr[d] = 32'h0; datI[d] = 32'h0;
  endtask

  // One full request: hold cyc/stb until ack or budget, then confirm ack lasted one cycle.
  task automatic runTxn(input int d, input bit wr, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] di, input int budget, output bit gotAck,
                        output int lat, output logic [31:0] rd, output bit leak);
    gotAck = 1'b0; lat = -1; rd = 32'h0; leak = 1'b0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; sel[d] = s; adr[d] = a; datI[d] = di;
    for (int n = 0; n < budget && !gotAck; n++) begin
      tick();
      if (ack[d]) begin
        gotAck = 1'b1; lat = n; rd = datO[d];
      end else if (datO[d] != 32'h0) begin
        leak = 1'b1;
      end
    end
    releaseBus(d);
    if (gotAck) begin
      if (wr && rd != 32'h0) leak = 1'b1;
      tick();
      if (ack[d] || datO[d] != 32'h0) leak = 1'b1;
    end
    if (wr && inWindow(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) memModel[d][wordIdx(a)][8*b +: 8] = di[8*b +: 8];
      end
    end
  endtask

  task automatic applyStimulus(input int d, input vec_t v, input string tag);
    bit gotAck, leak;
    int lat;
    logic [31:0] rd;
    runTxn(d, v.wr, v.sel, v.adr, v.dat, 30, gotAck, lat, rd, leak);
    checkOutput({tag, "_ack"}, 32'(gotAck), 32'(v.expAck));
    checkOutput({tag, "_leak"}, 32'(leak), 32'h0);
    if (v.expAck) checkOutput({tag, "_lat"}, 32'(lat), 32'(delayOf(d) + 1));
    if (v.expAck && !v.wr) checkOutput({tag, "_rd"}, rd, v.expRd);
  endtask

  vec_t vecs [16];

  initial begin
    bit gotAck, leak, sawAck;
    int lat, nAck, lastAck;
    logic [31:0] rd;
    logic [31:0] b2bAdr [4];
    logic [31:0] b2bExp [4];

    for (int d = 0; d < 2; d++) releaseBus(d);
    rstN = 1'b0;

    vecs[0]  = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'hF, 32'h3800_0020, 32'h1122_3344, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 4'h2, 32'h3800_0020, 32'h0000_AA00, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 4'hF, 32'h3800_0020, 32'h0,         1'b1, 32'h1122_AA44};
    vecs[5]  = '{1'b1, 4'hF, 32'h3800_0030, 32'h1234_5678, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h3800_0030, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 4'hF, 32'h3800_0030, 32'h0,         1'b1, 32'h1234_5678};
    vecs[8]  = '{1'b1, 4'hF, 32'h3000_0010, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 4'hF, 32'h3900_0010, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b1, 4'hF, 32'h3800_0FFC, 32'h0BAD_F00D, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 4'hF, 32'h3800_1FFC, 32'h0,         1'b1, 32'h0BAD_F00D};
    vecs[14] = '{1'b1, 4'hF, 32'h3800_0040, 32'h5555_5555, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 4'hF, 32'h3800_0050, 32'h1111_1111, 1'b1, 32'h0};

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'h0);
      checkOutput($sformatf("rst_dat%0d", d), datO[d], 32'h0);
    end
    rstN = 1'b1;
    tick();

    $display("[TB] vector table on DELAY=%0d", DELAY_A);
    for (int i = 0; i < 16; i++) applyStimulus(0, vecs[i], $sformatf("vec%0d", i));

    $display("[TB] abort by dropping cyc in WAIT");
    sawAck = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3800_0040; datI[0] = 32'hAAAA_AAAA;
    repeat (4) begin tick(); if (ack[0]) sawAck = 1'b1; end
    releaseBus(0);
    repeat (20) begin tick(); if (ack[0]) sawAck = 1'b1; end
    checkOutput("abort_noack", 32'(sawAck), 32'h0);
    runTxn(0, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 30, gotAck, lat, rd, leak);
    checkOutput("abort_rd_ack", 32'(gotAck), 32'h1);
    checkOutput("abort_rd_lat", 32'(lat), 32'(DELAY_A + 1));
    checkOutput("abort_rd_val", rd, 32'h5555_5555);

    $display("[TB] reset during WAIT");
    sawAck = 1'b0;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3800_0050; datI[0] = 32'h2222_2222;
    repeat (5) tick();
    rstN = 1'b0;
    releaseBus(0);
    tick();
    checkOutput("rstwait_ack", 32'(ack[0]), 32'h0);
    checkOutput("rstwait_dat", datO[0], 32'h0);
    rstN = 1'b1;
    repeat (15) begin tick(); if (ack[0]) sawAck = 1'b1; end
    checkOutput("rstwait_noack", 32'(sawAck), 32'h0);
    runTxn(0, 1'b0, 4'hF, 32'h3800_0050, 32'h0, 30, gotAck, lat, rd, leak);
    checkOutput("rstwait_rd_lat", 32'(lat), 32'(DELAY_A + 1));
    checkOutput("rstwait_rd_val", rd, 32'h1111_1111);

    $display("[TB] address/data changes mid-wait");
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3800_0060; datI[0] = 32'h600D_CAFE;
    repeat (3) tick();
    adr[0] = 32'h3800_0064; datI[0] = 32'h0; sel[0] = 4'h0; we[0] = 1'b0;
    sawAck = 1'b0;
    for (int n = 0; n < 20 && !sawAck; n++) begin tick(); sawAck = ack[0]; end
    releaseBus(0);
    checkOutput("midwait_ack", 32'(sawAck), 32'h1);
    tick();
    memModel[0][wordIdx(32'h3800_0060)] = 32'h600D_CAFE;
    runTxn(0, 1'b0, 4'hF, 32'h3800_0060, 32'h0, 30, gotAck, lat, rd, leak);
    checkOutput("midwait_rd_val", rd, 32'h600D_CAFE);

    $display("[TB] DELAY=0 back-to-back reads with stb held");
    runTxn(1, 1'b1, 4'hF, 32'h3800_0000, 32'hA0A0_A0A0, 10, gotAck, lat, rd, leak);
    checkOutput("d0_wr_lat", 32'(lat), 32'(DELAY_B + 1));
    runTxn(1, 1'b1, 4'hF, 32'h3800_0004, 32'hB1B1_B1B1, 10, gotAck, lat, rd, leak);
    b2bAdr = '{32'h3800_0000, 32'h3800_0004, 32'h3800_1000, 32'h3800_1004};
    b2bExp = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hA0A0_A0A0, 32'hB1B1_B1B1};
    nAck = 0; lastAck = -1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = b2bAdr[0];
    for (int c = 0; c < 20 && nAck < 4; c++) begin
      tick();
      if (ack[1]) begin
        checkOutput($sformatf("b2b_rd%0d", nAck), datO[1], b2bExp[nAck]);
        if (lastAck >= 0) checkOutput($sformatf("b2b_gap%0d", nAck), 32'(c - lastAck), 32'h2);
        lastAck = c;
        nAck++;
        if (nAck < 4) adr[1] = b2bAdr[nAck];
      end
    end
    releaseBus(1);
    checkOutput("b2b_count", 32'(nAck), 32'h4);
    tick();

    $display("[TB] random traffic against the word model");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        runTxn(d, 1'b1, 4'hF, 32'h3800_0000 + 32'((128 + i) * 4), $urandom, delayOf(d) + 4,
               gotAck, lat, rd, leak);
      end
      for (int t = 0; t < ((d == 0) ? 40 : 150); t++) begin
        bit hit, wr;
        logic [11:0] hi;
        logic [31:0] a, di;
        logic [3:0] s;
        hit = ($urandom_range(0, 7) != 0);
        hi = hit ? 12'h380 : 12'($urandom_range(0, 1) ? 12'h300 + 12'($urandom_range(0, 1) * 'h81) : 12'h37F);
        a = (32'(hi) << 20) + (32'($urandom_range(0, 255)) << 12)
          + 32'((128 + $urandom_range(0, 15)) * 4) + 32'($urandom_range(0, 3));
        wr = 1'($urandom_range(0, 1));
        s = 4'($urandom);
        di = $urandom;
        if (!wr) rd = memModel[d][wordIdx(a)];
        di = wr ? di : 32'h0;
        begin
          logic [31:0] expRd;
          expRd = rd;
          runTxn(d, wr, s, a, di, delayOf(d) + 4, gotAck, lat, rd, leak);
          checkOutput($sformatf("rnd%0d_%0d_ack", d, t), 32'(gotAck), 32'(hit));
          checkOutput($sformatf("rnd%0d_%0d_leak", d, t), 32'(leak), 32'h0);
          if (hit) checkOutput($sformatf("rnd%0d_%0d_lat", d, t), 32'(lat), 32'(delayOf(d) + 1));
          if (hit && !wr) checkOutput($sformatf("rnd%0d_%0d_rd", d, t), rd, expRd);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
